// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point field widths, bias and converter state encoding
package fp_pkg;

  localparam int EXP_W        = 8;
  localparam int MAN_W        = 23;
  localparam int BIAS         = 127;
  localparam int I2F_EXP_INIT = BIAS + 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } i2f_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round a normalized 32-bit magnitude to a 24-bit significand, nearest-even
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [31:0]      mag,
  input  logic [EXP_W-1:0] exp_in,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] man_out,
  output logic             inexact
);

  logic [23:0] sig;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [24:0] sum;

  assign sig      = mag[31:8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard & (sticky | sig[0]);
  assign sum      = {1'b0, sig} + {24'd0, round_up};

  // A carry out of the significand means it became 2^24: renormalize by one.
  assign exp_out  = sum[24] ? exp_in + EXP_W'(1) : exp_in;
  assign man_out  = sum[24] ? sum[23:1] : sum[22:0];
  assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_int_to_float.sv
// rtl/fp_int_to_float.sv - signed int32 to IEEE-754 single converter; FP_I2F_LZC_EN selects one-cycle normalize
module fp_int_to_float
  import fp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BIAS = 127
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_int,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            inexact
);

  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + XLEN - 1);

  i2f_state_t       state;
  logic             sign_q;
  logic [XLEN-1:0]  mag_q;
  logic [EXP_W-1:0] exp_q;

  logic [XLEN-1:0]  abs_in;
  logic [EXP_W-1:0] rnd_exp;
  logic [MAN_W-1:0] rnd_man;
  logic             rnd_inexact;

  // -2^31 negates to itself, which is exactly the unsigned magnitude wanted.
  assign abs_in = in_int[XLEN-1] ? (~in_int + XLEN'(1)) : in_int;

  fp_round_rne u_round (
    .mag     (mag_q),
    .exp_in  (exp_q),
    .exp_out (rnd_exp),
    .man_out (rnd_man),
    .inexact (rnd_inexact)
  );

`ifdef FP_I2F_LZC_EN
  logic [4:0]       lz;
  logic [XLEN-1:0]  norm_mag;
  logic [EXP_W-1:0] norm_exp;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (mag_q[i]) lz = 5'(XLEN - 1 - i);
    end
    norm_mag = mag_q << lz;
    norm_exp = exp_q - {3'b000, lz};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_int[XLEN-1];
            mag_q    <= abs_in;
            exp_q    <= EXP_INIT;
            in_ready <= 1'b0;
            if (abs_in == '0) begin
              result    <= '0;
              inexact   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
`ifdef FP_I2F_LZC_EN
          mag_q <= norm_mag;
          exp_q <= norm_exp;
          state <= ROUND;
`else
          if (mag_q[XLEN-1]) begin
            state <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
`endif
        end
        ROUND: begin
          result    <= {sign_q, rnd_exp, rnd_man};
          inexact   <= rnd_inexact;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
